instr_decode_queue: RTL and testbench

Parametrised, buffered instruction-decode stage. It sits between fetch and register-read. It accepts 32-bit instructions with their PC over a valid/ready handshake, splits each one into opcode, funct, register and immediate fields, and stores the decoded record in a DEPTH-entry FIFO. It presents the FIFO head to the downstream stage over a second valid/ready handshake, with a synchronous flush for branch redirects.

---
 rtl/decode_pkg.sv | 39 +++
 rtl/instr_field_extract.sv | 27 ++
 rtl/instr_decode_queue.sv | 103 ++++++++++
 tb/tb_instr_decode_queue.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction field positions
// and the decoded record carried between pipeline stages.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 27;
  localparam int RS_HI    = 26;
  localparam int RS_LO    = 22;
  localparam int RT_HI    = 21;
  localparam int RT_LO    = 17;
  localparam int RD_HI    = 16;
  localparam int RD_LO    = 12;
  localparam int FUNCT_HI = 3;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;
  localparam int IMM26_HI = 25;
  localparam int IMM26_LO = 0;

  localparam int IMM_W   = IMM_HI - IMM_LO + 1;
  localparam int IMM26_W = IMM26_HI - IMM26_LO + 1;

  // Wide members are sized XLEN_MAX; users keep
  // the low XLEN bits (sign extension already
  // fills the upper bits correctly).
  typedef struct packed {
    logic [4:0]          opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [3:0]          funct;
    logic [XLEN_MAX-1:0] imm;
    logic [XLEN_MAX-1:0] imm26;
    logic [XLEN_MAX-1:0] pc;
  } decoded_instr_t;

endpackage

// File: rtl/instr_field_extract.sv
// Combinational field split: instr, pc in;
// decoded_instr_t out (imm/imm26 sign-extended).
module instr_field_extract
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_instr_t  dec
);

  always_comb begin
    dec        = '0;
    dec.opcode = instr[OPC_HI:OPC_LO];
    dec.rs     = instr[RS_HI:RS_LO];
    dec.rt     = instr[RT_HI:RT_LO];
    dec.rd     = instr[RD_HI:RD_LO];
    dec.funct  = instr[FUNCT_HI:FUNCT_LO];
    dec.imm    = {{(XLEN_MAX-IMM_W){instr[IMM_HI]}},
                  instr[IMM_HI:IMM_LO]};
    dec.imm26  = {{(XLEN_MAX-IMM26_W){instr[IMM26_HI]}},
                  instr[IMM26_HI:IMM26_LO]};
    dec.pc     = XLEN_MAX'(pc);
  end

endmodule

// File: rtl/instr_decode_queue.sv
// Buffered decode stage: valid/ready in, DEPTH-entry FIFO
// of decoded records, valid/ready out, sync flush, count.
module instr_decode_queue
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [XLEN-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4:0]                 out_opcode,
  output logic [4:0]                 out_rs,
  output logic [4:0]                 out_rt,
  output logic [4:0]                 out_rd,
  output logic [3:0]                 out_funct,
  output logic [XLEN-1:0]            out_imm,
  output logic [XLEN-1:0]            out_imm26,
  output logic [XLEN-1:0]            out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  decoded_instr_t mem [DEPTH];
  decoded_instr_t in_dec;
  decoded_instr_t head;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          primed;
  logic          push;
  logic          pop;

  instr_field_extract #(.XLEN(XLEN)) u_extract (
    .instr (in_instr),
    .pc    (in_pc),
    .dec   (in_dec)
  );

  assign in_ready  = (cnt != CW'(DEPTH)) & ~flush;
  assign out_valid = (cnt != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_dec;
  end

  // primed masks unwritten storage until the
  // first push after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      primed <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        primed <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head = primed ? mem[rd_ptr] : '0;

  assign out_opcode = head.opcode;
  assign out_rs     = head.rs;
  assign out_rt     = head.rt;
  assign out_rd     = head.rd;
  assign out_funct  = head.funct;
  assign out_imm    = head.imm[XLEN-1:0];
  assign out_imm26  = head.imm26[XLEN-1:0];
  assign out_pc     = head.pc[XLEN-1:0];

  if (XLEN < XLEN_MAX) begin : g_trim
    logic unused_hi;
    assign unused_hi = ^{head.imm[XLEN_MAX-1:XLEN],
                         head.imm26[XLEN_MAX-1:XLEN],
                         head.pc[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_instr_decode_queue.sv
// Scoreboard bench for instr_decode_queue
// (XLEN=32, DEPTH=4).
module tb_instr_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [3:0]      out_funct;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_imm26;
  logic [XLEN-1:0] out_pc;
  logic [2:0]      count;

  instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_funct  (out_funct),
    .out_imm    (out_imm),
    .out_imm26  (out_imm26),
    .out_pc     (out_pc),
    .count      (count)
  );

  typedef struct packed {
    logic [4:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [31:0] imm;
    logic [31:0] imm26;
    logic [31:0] pc;
  } rec_t;

  rec_t q[$];
  rec_t got;
  rec_t want;
  int   checks;
  int   fails;
  logic did_push;
  logic did_pop;
  logic s_valid;
  logic s_ready;
  logic [2:0] s_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rec_t model(input logic [31:0] i,
                                 input logic [31:0] p);
    rec_t r;
    r.opc   = i[31:27];
    r.rs    = i[26:22];
    r.rt    = i[21:17];
    r.rd    = i[16:12];
    r.funct = i[3:0];
    r.imm   = {{16{i[15]}}, i[15:0]};
    r.imm26 = {{6{i[25]}}, i[25:0]};
    r.pc    = p;
    return r;
  endfunction

  // Drive one cycle; snapshot outputs before the edge.
  task automatic step(input logic v, input logic [31:0] i,
                      input logic [31:0] p, input logic r,
                      input logic f);
    @(negedge clk);
    in_valid  = v;
    in_instr  = i;
    in_pc     = p;
    out_ready = r;
    flush     = f;
    #1;
    did_push = in_valid & in_ready;
    did_pop  = out_valid & out_ready & ~flush;
    s_valid  = out_valid;
    s_ready  = in_ready;
    s_count  = count;
    got = '{out_opcode, out_rs, out_rt, out_rd, out_funct,
            out_imm, out_imm26, out_pc};
    if (did_push) q.push_back(model(i, p));
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    out_ready = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (count !== 3'd0) begin
      fails++;
      $display("FAIL reset_count: got %0d want 0", count);
    end
    checks++;
    if ({out_opcode, out_imm, out_pc} !== '0) begin
      fails++;
      $display("FAIL reset_fields: got %h/%h/%h want 0",
               out_opcode, out_imm, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    step(1'b1, 32'h0A46_8003, 32'h100, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_valid: got %b want 1", s_valid);
    end
    checks++;
    if (got !== {5'd1, 5'd9, 5'd3, 5'd8, 4'd3,
                 32'hFFFF_8003, 32'hFE46_8003, 32'h100}) begin
      fails++;
      $display("FAIL single_fields: got %h want 0a468003 decode",
               got);
    end
    if (did_pop) begin
      checks++;
      want = q.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL single_pop: got %h want %h", got, want);
      end
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b0 || q.size() != 0) begin
      fails++;
      $display("FAIL single_empty: got valid=%b pend=%0d want 0/0",
               s_valid, q.size());
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (did_pop) begin
        checks++;
        want = q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL %s_drain: got %h want %h",
                   name, got, want);
        end
      end
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: got %0d pending want 0",
               name, q.size());
      q.delete();
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 32'h1234_0000 + k, 32'h200 + 4 * k,
           1'b0, 1'b0);
      checks++;
      if (s_ready !== (k < 4) || s_count !== 3'(k)) begin
        fails++;
        $display("FAIL fill_%0d: got rdy=%b cnt=%0d want %b/%0d",
                 k, s_ready, s_count, k < 4, k);
      end
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (s_count !== 3'd4 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL fill_full: got cnt=%0d rdy=%b want 4/0",
               s_count, s_ready);
    end
    if (did_pop) begin
      checks++;
      want = q.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL fill_pop: got %h want %h", got, want);
      end
    end
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (s_ready !== 1'b1 || s_count !== 3'd3) begin
      fails++;
      $display("FAIL fill_release: got rdy=%b cnt=%0d want 1/3",
               s_ready, s_count);
    end
    drain("fill");
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL fill_fifth: got valid=%b want 0", s_valid);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, $urandom, 32'h1000 + 4 * k, 1'b1, 1'b0);
      checks++;
      if (s_count > 3'd1 || (k > 0 && s_valid !== 1'b1)) begin
        fails++;
        $display("FAIL stream_%0d: got cnt=%0d valid=%b want <=1/1",
                 k, s_count, s_valid);
      end
      if (did_pop) begin
        checks++;
        want = q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL stream_pop: got %h want %h", got, want);
        end
      end
    end
    drain("stream");
  endtask

  task automatic test_wrap();
    int sent = 0;
    int n = 0;
    while ((sent < 6 || q.size() > 0) && n < 80) begin
      step(sent < 6, $urandom, 32'h3000 + 4 * sent,
           1'($urandom_range(0, 1)), 1'b0);
      if (did_push) sent++;
      if (did_pop) begin
        checks++;
        want = q.pop_front();
        if (got !== want) begin
          fails++;
          $display("FAIL wrap_pop: got %h want %h", got, want);
        end
      end
      n++;
    end
    checks++;
    if (sent != 6 || q.size() != 0) begin
      fails++;
      $display("FAIL wrap_timeout: got sent=%0d pend=%0d want 6/0",
               sent, q.size());
      q.delete();
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'hA000_0000 + k, 32'h400 + 4 * k,
           1'b0, 1'b0);
    step(1'b1, 32'hBEEF_0001, 32'h500, 1'b0, 1'b1);
    checks++;
    if (s_count !== 3'd3 || s_ready !== 1'b0) begin
      fails++;
      $display("FAIL flush_pre: got cnt=%0d rdy=%b want 3/0",
               s_count, s_ready);
    end
    q.delete();
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (s_count !== 3'd0 || s_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_post: got cnt=%0d valid=%b want 0/0",
               s_count, s_valid);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (s_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_drop: got valid=%b want 0", s_valid);
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 32'h0C00_0001, 32'h600, 1'b0, 1'b0);
    step(1'b1, 32'h0C00_0002, 32'h604, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd2) begin
      fails++;
      $display("FAIL areset_pre: got %0d want 2", count);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      fails++;
      $display("FAIL areset_clear: got valid=%b cnt=%0d want 0/0",
               out_valid, count);
    end
    #1 rst_n = 1'b1;
    q.delete();
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (s_ready !== 1'b1 || s_valid !== 1'b0 ||
        s_count !== 3'd0) begin
      fails++;
      $display("FAIL areset_post: got rdy=%b valid=%b cnt=%0d want 1/0/0",
               s_ready, s_valid, s_count);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
